// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Optional round-robin arbitration is enabled with RAM_ARB_RR_EN.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the CPU/DMA request pair.
// RAM_ARB_RR_EN selects round-robin on ties; otherwise the CPU always wins.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
`ifdef RAM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = cpu_req | dma_req;
`ifdef RAM_ARB_RR_EN
    if (cpu_req && dma_req) begin
      winner = ~last_grant;  // the port not served last wins a tie
    end else begin
      winner = dma_req ? PORT_DMA : PORT_CPU;
    end
`else
    winner = (dma_req && !cpu_req) ? PORT_DMA : PORT_CPU;
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter and strobe sequencer for the shared synchronous RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration instead of fixed CPU priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_ack,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_gnt,
  output logic              o_dma_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_enable_x,
  output logic              o_ram_write_x,
  input  logic [DATA_W-1:0] i_ram_data
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              en_x_q, en_x_d;
  logic              wr_x_q, wr_x_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic              any_req;
  logic              winner;
`ifdef RAM_ARB_RR_EN
  logic              last_q, last_d;
`endif

  ram_arb_pick u_pick (
    .cpu_req    (i_cpu_req),
    .dma_req    (i_dma_req),
`ifdef RAM_ARB_RR_EN
    .last_grant (last_q),
`endif
    .any_req    (any_req),
    .winner     (winner)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first, so no branch can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    en_x_d    = en_x_q;
    wr_x_d    = wr_x_q;
    cpu_gnt_d = cpu_gnt_q;
    dma_gnt_d = dma_gnt_q;
    cpu_ack_d = 1'b0;
    dma_ack_d = 1'b0;
`ifdef RAM_ARB_RR_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          en_x_d  = 1'b0;
          if (winner == PORT_DMA) begin
            addr_d    = i_dma_addr;
            data_d    = i_dma_wdata;
            wr_x_d    = ~i_dma_we;
            dma_gnt_d = 1'b1;
          end else begin
            addr_d    = i_cpu_addr;
            data_d    = i_cpu_wdata;
            wr_x_d    = ~i_cpu_we;
            cpu_gnt_d = 1'b1;
          end
`ifdef RAM_ARB_RR_EN
          last_d = winner;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (wr_x_q) rdata_d = i_ram_data;  // strobe high means this was a read
          en_x_d    = 1'b1;
          wr_x_d    = 1'b1;
          cpu_ack_d = cpu_gnt_q;
          dma_ack_d = dma_gnt_q;
          state_d   = RECOVER;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RECOVER: begin
        cpu_gnt_d = 1'b0;
        dma_gnt_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      en_x_q    <= 1'b1;
      wr_x_q    <= 1'b1;
      cpu_gnt_q <= 1'b0;
      dma_gnt_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      en_x_q    <= en_x_d;
      wr_x_q    <= wr_x_d;
      cpu_gnt_q <= cpu_gnt_d;
      dma_gnt_q <= dma_gnt_d;
      cpu_ack_q <= cpu_ack_d;
      dma_ack_q <= dma_ack_d;
    end
  end

`ifdef RAM_ARB_RR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) last_q <= PORT_DMA;
    else       last_q <= last_d;
  end
`endif

  assign o_cpu_gnt      = cpu_gnt_q;
  assign o_cpu_ack      = cpu_ack_q;
  assign o_dma_gnt      = dma_gnt_q;
  assign o_dma_ack      = dma_ack_q;
  assign o_rdata        = rdata_q;
  assign o_ram_addr     = addr_q;
  assign o_ram_data     = data_q;
  assign o_ram_enable_x = en_x_q;
  assign o_ram_write_x  = wr_x_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: drivers push expected accesses, a negedge
// monitor pops and checks each ack against strobe timing, address and data.
module tb_ram_arbiter;

  localparam int W = 2;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic       port;
    logic       we;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        cpu_gnt, cpu_ack, dma_gnt, dma_ack;
  logic [7:0]  rdata, ram_data, ram_rdata;
  logic [15:0] ram_addr;
  logic        ram_en_x, ram_wr_x;

  logic [7:0]  ram [0:65535];
  logic [7:0]  model_mem [logic [15:0]];
  logic [7:0]  model_last = 8'h00;
  logic        model_ptr  = 1'b1;
  exp_t        sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(W)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt), .o_cpu_ack(cpu_ack),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_gnt(dma_gnt), .o_dma_ack(dma_ack),
    .o_rdata(rdata), .o_ram_addr(ram_addr), .o_ram_data(ram_data),
    .o_ram_enable_x(ram_en_x), .o_ram_write_x(ram_wr_x), .i_ram_data(ram_rdata)
  );

  // Synchronous RAM model; reset preloads the location read by the first test.
  always @(posedge clk) begin
    if (rst) ram[16'h1234] <= 8'hA5;
    else if (!ram_en_x && !ram_wr_x) ram[ram_addr] <= ram_data;
  end
  assign ram_rdata = ram[ram_addr];

  // Two extra instances cover the WAIT_CYCLES extremes.
  logic        a_req [2];
  logic        a_gnt [2], a_ack [2], a_dgnt [2], a_dack [2], a_en [2], a_wr [2];
  logic [7:0]  a_rdata [2], a_rdat [2];
  logic [15:0] a_raddr [2];

  for (genvar g = 0; g < 2; g++) begin : g_aux
    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(g == 0 ? 1 : 15)) u_aux (
      .i_clk(clk), .i_rst(rst),
      .i_cpu_req(a_req[g]), .i_cpu_we(1'b0), .i_cpu_addr(16'h0ABC), .i_cpu_wdata(8'h00),
      .o_cpu_gnt(a_gnt[g]), .o_cpu_ack(a_ack[g]),
      .i_dma_req(1'b0), .i_dma_we(1'b0), .i_dma_addr(16'h0000), .i_dma_wdata(8'h00),
      .o_dma_gnt(a_dgnt[g]), .o_dma_ack(a_dack[g]),
      .o_rdata(a_rdata[g]), .o_ram_addr(a_raddr[g]), .o_ram_data(a_rdat[g]),
      .o_ram_enable_x(a_en[g]), .o_ram_write_x(a_wr[g]), .i_ram_data(8'h5A)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic port, input logic we, input logic [15:0] addr,
                      input logic [7:0] wdata, input logic gap);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.gap = gap;
    if (we) begin
      model_mem[addr] = wdata;
      e.rdata = model_last;
    end else begin
      e.rdata = model_mem.exists(addr) ? model_mem[addr] : 8'h00;
      model_last = e.rdata;
    end
    sb.push_back(e);
  endtask

  // Each port keeps req high until it has completed its count of accesses.
  task automatic run_both(input int nc, input logic cwe, input logic [15:0] caddr,
                          input logic [7:0] cwd, input int nd, input logic dwe,
                          input logic [15:0] daddr, input logic [7:0] dwd);
    int rc = nc, rd = nd, dc = 0, dd = 0, t = 0;
    logic w;
    bit first = 1'b1;
    while (rc > 0 || rd > 0) begin
      if (rc > 0 && rd > 0) w = RR ? ~model_ptr : 1'b0;
      else                  w = (rc == 0);
      if (w) push(1'b1, dwe, daddr, dwd, !first);
      else   push(1'b0, cwe, caddr, cwd, !first);
      model_ptr = w;
      first = 1'b0;
      if (w) rd--; else rc--;
    end
    cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd; cpu_req = (nc > 0);
    dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_req = (nd > 0);
    while ((dc < nc || dd < nd) && t < 400) begin
      @(posedge clk); #1; t++;
      if (cpu_ack) begin dc++; if (dc == nc) cpu_req = 1'b0; end
      if (dma_ack) begin dd++; if (dd == nd) dma_req = 1'b0; end
    end
    check("drive_timeout", 32'(t >= 400), 32'd0);
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: tallies strobe cycles per access and checks each ack against the scoreboard.
  int          en_cnt = 0, wr_cnt = 0, g_cyc = 0, prev_ack = 0;
  bit          unstable = 1'b0;
  logic [15:0] acc_addr = '0;
  logic [7:0]  acc_data = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_cnt = 0; wr_cnt = 0; unstable = 1'b0;
      end else begin
        if (cpu_gnt && dma_gnt) check("dual_grant", 32'd1, 32'd0);
        if (!ram_en_x) begin
          en_cnt++;
          if (!ram_wr_x) wr_cnt++;
          if (en_cnt == 1) begin
            acc_addr = ram_addr; acc_data = ram_data; g_cyc = cyc;
          end else if (ram_addr !== acc_addr || ram_data !== acc_data) begin
            unstable = 1'b1;
          end
        end
        if (cpu_ack || dma_ack) begin
          if (sb.size() == 0) begin
            check("unexpected_ack", 32'({cpu_ack, dma_ack}), 32'd0);
          end else begin
            e = sb.pop_front();
            check("ack_port", 32'({cpu_ack, dma_ack}), e.port ? 32'd1 : 32'd2);
            check("gnt_in_recover", 32'({cpu_gnt, dma_gnt}), e.port ? 32'd1 : 32'd2);
            check("rdata", 32'(rdata), 32'(e.rdata));
            check("enable_cycles", 32'(en_cnt), 32'(W));
            check("write_cycles", 32'(wr_cnt), e.we ? 32'(W) : 32'd0);
            check("access_addr", 32'(acc_addr), 32'(e.addr));
            check("recover_addr", 32'(ram_addr), 32'(e.addr));
            check("recover_strobes", 32'({ram_en_x, ram_wr_x}), 32'd3);
            check("held_stable", 32'(unstable), 32'd0);
            check("ack_latency", 32'(cyc - g_cyc + 1), 32'(W + 1));
            if (e.we) check("write_data", 32'(acc_data), 32'(e.wdata));
            if (e.gap) check("ack_spacing", 32'(cyc - prev_ack), 32'(W + 2));
          end
          prev_ack = cyc;
          en_cnt = 0; wr_cnt = 0; unstable = 1'b0;
        end else if (ram_en_x && !cpu_gnt && !dma_gnt) begin
          en_cnt = 0; wr_cnt = 0; unstable = 1'b0;
        end
      end
    end
  end

  task automatic aux_latency(input int g, input int wait_c);
    int n = 0;
    a_req[g] = 1'b1;
    while (n < 40) begin
      @(posedge clk); #1; n++;
      if (a_ack[g]) break;
    end
    check("aux_ack_latency", 32'(n), 32'(wait_c + 1));
    check("aux_rdata", 32'(a_rdata[g]), 32'h5A);
    check("aux_recover_addr", 32'(a_raddr[g]), 32'h0ABC);
    check("aux_strobes", 32'({a_en[g], a_wr[g], a_dgnt[g], a_dack[g]}), 32'hC);
    check("aux_wdata", 32'(a_rdat[g]), 32'h00);
    a_req[g] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    model_mem[16'h1234] = 8'hA5;
    a_req[0] = 1'b0; a_req[1] = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", 32'({ram_en_x, ram_wr_x}), 32'd3);
    check("rst_addr_data", 32'({ram_addr, ram_data}), 32'd0);
    check("rst_gnt_ack", 32'({cpu_gnt, dma_gnt, cpu_ack, dma_ack}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_both(1, 1'b0, 16'h1234, 8'h00, 0, 1'b0, 16'h0000, 8'h00);
    run_both(0, 1'b0, 16'h0000, 8'h00, 1, 1'b1, 16'h00FF, 8'h3C);
    run_both(1, 1'b0, 16'h00FF, 8'h00, 0, 1'b0, 16'h0000, 8'h00);
    run_both(1, 1'b0, 16'h1234, 8'h00, 1, 1'b1, 16'h0041, 8'h11);
    run_both(1, 1'b0, 16'h0041, 8'h00, 1, 1'b1, 16'h0042, 8'h22);
    run_both(4, 1'b0, 16'h1234, 8'h00, 2, 1'b1, 16'h0040, 8'h77);

    // Reset lands in the second ACCESS cycle of a CPU write; no ack may follow.
    cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h99; cpu_req = 1'b1;
    @(posedge clk); #1;
    check("abort_granted", 32'({cpu_gnt, ram_en_x, ram_wr_x}), 32'h4);
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    model_ptr = 1'b1; model_last = 8'h00;
    @(posedge clk); #1;
    check("abort_strobes", 32'({ram_en_x, ram_wr_x}), 32'd3);
    check("abort_gnt_ack", 32'({cpu_gnt, dma_gnt, cpu_ack, dma_ack}), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    run_both(1, 1'b0, 16'h00FF, 8'h00, 0, 1'b0, 16'h0000, 8'h00);
    run_both(0, 1'b0, 16'h0000, 8'h00, 1, 1'b0, 16'h0042, 8'h00);

    aux_latency(0, 1);
    aux_latency(1, 15);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
